// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding, constants and helpers for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = $clog2(WORD_BYTES);
  localparam int CNT_W      = 4;

  function automatic logic word_aligned(input logic [ADDR_LSB-1:0] lsb);
    return lsb == '0;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MA-stage load/store bus between pipeline (master) and responder (slave)
interface dmem_responder_if;

  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        rvalid;
  logic        memstall;
  logic        misalign;

  modport master (
    output memread, memwrite, addr, writedata,
    input  readdata, rvalid, memstall, misalign
  );

  modport slave (
    input  memread, memwrite, addr, writedata,
    output readdata, rvalid, memstall, misalign
  );

endinterface

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM with registered read data (cleared by reset, array is not)
module dmem_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wd,
  output logic [31:0]           rd
);

  logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] r_rd;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wd;
    end
  end

  // Read register holds its value until the next enabled read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd <= '0;
    end else if (re) begin
      r_rd <= r_mem[idx];
    end
  end

  assign rd = r_rd;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder with IDLE/BUSY/DONE handshake
// Optional macro DMEM_POSTED_WRITE_EN: aligned stores complete in IDLE without stalling.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  dmem_state_t r_state;
  dmem_state_t w_next_state;

  logic [CNT_W-1:0]      r_cnt;
  logic                  r_store;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [ADDR_LSB-1:0]   r_lsb;
  logic [31:0]           r_wd;
  logic                  r_misalign;
  logic                  r_posted_ack;

  logic                  w_req;
  logic                  w_posted;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_access_ok;
  logic                  w_we;
  logic                  w_re;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_wd;
  logic [31:0]           w_rd;
  logic                  w_addr_unused;

  assign w_req = bus.memread | bus.memwrite;

`ifdef DMEM_POSTED_WRITE_EN
  logic w_in_aligned;
  assign w_in_aligned = word_aligned(bus.addr[ADDR_LSB-1:0]);
  assign w_posted     = (r_state == ST_IDLE) && bus.memwrite && w_in_aligned;
`else
  assign w_posted = 1'b0;
`endif

  assign w_accept    = (r_state == ST_IDLE) && w_req && !w_posted;
  assign w_last      = (r_state == ST_BUSY) && (r_cnt == CNT_W'(1));
  // Reset on the access edge aborts the pending store/load
  assign w_access_ok = w_last && word_aligned(r_lsb) && !reset;
  assign w_we        = (w_access_ok && r_store) || (w_posted && !reset);
  assign w_re        = w_access_ok && !r_store;
  assign w_idx       = w_posted ? bus.addr[DEPTH_LOG2+ADDR_LSB-1:ADDR_LSB] : r_idx;
  assign w_wd        = w_posted ? bus.writedata : r_wd;

  assign w_addr_unused = ^bus.addr[31:DEPTH_LOG2+ADDR_LSB];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_BUSY;
      ST_BUSY: if (w_last) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.memstall = w_accept || (r_state == ST_BUSY);
    bus.rvalid   = (r_state == ST_DONE) || r_posted_ack;
    bus.misalign = r_misalign;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_store      <= 1'b0;
      r_idx        <= '0;
      r_lsb        <= '0;
      r_wd         <= '0;
      r_misalign   <= 1'b0;
      r_posted_ack <= 1'b0;
    end else begin
      r_posted_ack <= w_posted;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_store <= bus.memwrite;
            r_idx   <= bus.addr[DEPTH_LOG2+ADDR_LSB-1:ADDR_LSB];
            r_lsb   <= bus.addr[ADDR_LSB-1:0];
            r_wd    <= bus.writedata;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_misalign <= !word_aligned(r_lsb);
          end
        end
        ST_DONE: r_misalign <= 1'b0;
        default: ;
      endcase
    end
  end

  dmem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (w_we),
    .re    (w_re),
    .idx   (w_idx),
    .wd    (w_wd),
    .rd    (w_rd)
  );

  assign bus.readdata = w_rd;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and randomized checks of dmem_responder against a word-array model
module tb_dmem_responder;

  localparam int W  = 2;
  localparam int DL = 10;
`ifdef DMEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_LOG2  (DL),
    .WAIT_CYCLES (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_mem [int];
  logic [31:0] model_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.addr      = '0;
    bus.writedata = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_bus();
    end
  endtask

  // One pipeline request; the request is withdrawn once memstall is seen low
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    bit          aligned;
    bit          fast;
    int          idx;
    int          k;
    int          stalls;
    bit          seen;
    bit          consumed;
    logic [31:0] got_rd;
    logic        got_mis;
    logic        got_stall;

    aligned  = (a[1:0] == 2'b00);
    fast     = POSTED && wr && aligned;
    idx      = int'(a[DL+1:2]);
    k        = 0;
    stalls   = 0;
    seen     = 1'b0;
    consumed = 1'b0;
    got_rd   = '0;
    got_mis  = 1'b0;
    got_stall = 1'b0;

    if (aligned) begin
      if (wr) model_mem[idx] = d;
      else if (model_mem.exists(idx)) model_rd = model_mem[idx];
    end

    @(negedge clk);
    bus.memread   = rd;
    bus.memwrite  = wr;
    bus.addr      = a;
    bus.writedata = d;
    #1;
    while (!seen && k < 64) begin
      if (bus.rvalid) begin
        seen      = 1'b1;
        got_rd    = bus.readdata;
        got_mis   = bus.misalign;
        got_stall = bus.memstall;
      end else begin
        if (bus.memstall) stalls++;
        else consumed = 1'b1;
        @(negedge clk);
        if (consumed) idle_bus();
        #1;
        k++;
      end
    end

    check_eq({tag, " rvalid"}, 32'(seen), 32'd1);
    check_eq({tag, " latency"}, k, fast ? 1 : W + 1);
    check_eq({tag, " stalls"}, stalls, fast ? 0 : W + 1);
    check_eq({tag, " stall_at_done"}, 32'(got_stall), 32'd0);
    check_eq({tag, " misalign"}, 32'(got_mis), 32'(!aligned));
    check_eq({tag, " readdata"}, got_rd, model_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          op;
    int          pidx;

    idle_bus();
    model_rd = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("reset readdata", bus.readdata, 32'd0);
    check_eq("reset rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("reset memstall", 32'(bus.memstall), 32'd0);
    check_eq("reset misalign", 32'(bus.misalign), 32'd0);

    access(1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, "st10");
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, "ld10");
    access(1'b1, 1'b0, 32'h0000_1010, 32'h0, "ld1010_alias");
    access(1'b0, 1'b1, 32'h0000_0013, 32'h1, "st13_mis");
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, "ld10_after_mis");
    access(1'b1, 1'b0, 32'h0000_0011, 32'h0, "ld11_mis");
    access(1'b1, 1'b1, 32'h0000_0020, 32'h55, "both20");
    idle_cycles(1);
    access(1'b1, 1'b0, 32'h0000_0020, 32'h0, "ld20");
    access(1'b0, 1'b1, 32'h0000_0030, 32'h1234, "st30");

    // Abort in the second BUSY cycle; posted builds abort a load instead
    @(negedge clk);
    bus.memread   = POSTED;
    bus.memwrite  = !POSTED;
    bus.addr      = 32'h0000_0030;
    bus.writedata = 32'h77;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_bus();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_rd = '0;
    check_eq("abort rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("abort memstall", 32'(bus.memstall), 32'd0);
    check_eq("abort readdata", bus.readdata, 32'd0);
    @(negedge clk);
    #1;
    check_eq("abort rvalid2", 32'(bus.rvalid), 32'd0);
    access(1'b1, 1'b0, 32'h0000_0030, 32'h0, "ld30_after_abort");

    access(1'b0, 1'b1, 32'h0000_0040, 32'h9, "st40");
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, "ld40");

    for (int i = 0; i < 16; i++) begin
      access(1'b0, 1'b1, 32'h100 + 32'(i * 4), $urandom, "pool_init");
    end

    for (int n = 0; n < 300; n++) begin
      op   = $urandom_range(0, 2);
      pidx = $urandom_range(0, 15);
      a    = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'(pidx * 4));
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      access(op != 1, op != 0, a, $urandom, "rand");
      idle_cycles($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
